// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-bank write arbiter.
// Holds the FSM state encoding, grant encoding and default bank geometry.
package regfile_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } arb_state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/regfile_write_arbiter_arb.sv
// Combinational two-way round-robin grant. A lone valid requester always wins;
// with both valid, the requester that was not granted most recently wins.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic valid_a,
  input  logic valid_b,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);

  always_comb begin
    grant_a = valid_a && (!valid_b || (last_grant == GRANT_B));
    grant_b = valid_b && (!valid_a || (last_grant == GRANT_A));
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-bank write port between requesters A and B, and runs a clear sweep.
// Optional per-requester transfer counters are built when REGFILE_ARB_STATS_EN is defined.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int            N         = N_DEF,
  parameter int            W         = W_DEF,
  parameter logic [W-1:0]  CLEAR_VAL = '0
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  input  logic [N-1:0] a_addr,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [N-1:0] b_addr,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  input  logic         clr_start,
  output logic         busy,
  output logic         rf_we,
  output logic [N-1:0] rf_addr,
  output logic [W-1:0] rf_data,
  output logic         last_grant
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]  cnt_a,
  output logic [15:0]  cnt_b
`endif
);

  localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};
  localparam logic [N-1:0] ADDR_ONE  = N'(1);

  arb_state_t   state_q, state_d;
  logic [N-1:0] clr_cnt_q, clr_cnt_d;
  logic         last_grant_q, last_grant_d;
  logic         busy_q, busy_d;

  logic         vld_p0;
  logic [N-1:0] addr_p0;
  logic [W-1:0] data_p0;

  logic         vld_p1;
  logic [N-1:0] addr_p1;
  logic [W-1:0] data_p1;

  logic         gnt_a, gnt_b;
  logic         arb_en;
  logic         a_xfer, b_xfer;

  rr_arbiter2 u_rr (
    .valid_a    (a_valid),
    .valid_b    (b_valid),
    .last_grant (last_grant_q),
    .grant_a    (gnt_a),
    .grant_b    (gnt_b)
  );

  // Stage p0: handshake, arbitration and next-state selection
  always_comb begin
    arb_en  = (state_q == ARB_IDLE) && !clr_start;
    a_ready = arb_en && gnt_a;
    b_ready = arb_en && gnt_b;
    a_xfer  = a_valid && a_ready;
    b_xfer  = b_valid && b_ready;
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_grant_d = last_grant_q;
    busy_d       = 1'b0;
    vld_p0       = 1'b0;
    addr_p0      = addr_p1;
    data_p0      = data_p1;
    case (state_q)
      ARB_IDLE: begin
        if (clr_start) begin
          state_d   = ARB_CLEAR;
          clr_cnt_d = '0;
          busy_d    = 1'b1;
          vld_p0    = 1'b1;
          addr_p0   = '0;
          data_p0   = CLEAR_VAL;
        end else if (a_xfer) begin
          last_grant_d = GRANT_A;
          vld_p0       = 1'b1;
          addr_p0      = a_addr;
          data_p0      = a_data;
        end else if (b_xfer) begin
          last_grant_d = GRANT_B;
          vld_p0       = 1'b1;
          addr_p0      = b_addr;
          data_p0      = b_data;
        end
      end
      ARB_CLEAR: begin
        // clr_cnt_q is the address on the bank this cycle; busy tracks the CLEAR state exactly
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ARB_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_ONE;
          busy_d    = 1'b1;
          vld_p0    = 1'b1;
          addr_p0   = clr_cnt_q + ADDR_ONE;
          data_p0   = CLEAR_VAL;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Stage p1: registered bank write port and control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      clr_cnt_q    <= '0;
      last_grant_q <= GRANT_B;
      busy_q       <= 1'b0;
      vld_p1       <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      vld_p1       <= vld_p0;
      addr_p1      <= addr_p0;
      data_p1      <= data_p0;
    end
  end

  assign rf_we      = vld_p1;
  assign rf_addr    = addr_p1;
  assign rf_data    = data_p1;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;

`ifdef REGFILE_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_a_q, cnt_b_q;

  // Stage p1: transfer counters, clear writes never reach these
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (a_xfer) cnt_a_q <= sat_inc16(cnt_a_q);
      if (b_xfer) cnt_b_q <= sat_inc16(cnt_b_q);
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule
